// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer
//
// Sequences one N-byte SPI frame through a byte-level SPI master. It shifts out
// the latched word one byte at a time and rebuilds the received bytes into a
// parallel word. Frames start from a manual strobe or from a periodic timer.
// Each master handshake is guarded by a timeout. A trigger that arrives while
// a frame is in flight is flagged as an overrun and dropped.
//
// Ports:
//   i_Clk, i_Rst_L       clock, asynchronous active-low reset
//   i_Mode               0 = manual (i_Start), 1 = periodic timer
//   i_Start              single-cycle start strobe (manual mode only)
//   i_TX_Word            frame payload, latched when the frame starts
//   i_Clear_Err          clears the sticky error flags
//   o_Busy / o_Done      frame in progress / one-cycle completion pulse
//   o_RX_Word            last completed received frame
//   o_Frame_Count        completed frames, wraps at 16 bits
//   o_Timeout/o_Overrun  sticky error flags
//   o_M_* / i_M_*        byte handshake to and from the SPI master
module spi_frame_sequencer #(
  parameter int unsigned NUM_BYTES    = 4,
  parameter bit          LSB_FIRST    = 1'b1,
  parameter int unsigned PERIOD_CLKS  = 1048576,
  parameter int unsigned TIMEOUT_CLKS = 4096,
  localparam int unsigned CW = $clog2(NUM_BYTES + 1),
  localparam int unsigned WW = 8 * NUM_BYTES
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Mode,
  input  logic          i_Start,
  input  logic [WW-1:0] i_TX_Word,
  input  logic          i_Clear_Err,
  output logic          o_Busy,
  output logic          o_Done,
  output logic [WW-1:0] o_RX_Word,
  output logic [15:0]   o_Frame_Count,
  output logic          o_Timeout,
  output logic          o_Overrun,
  output logic [CW-1:0] o_M_TX_Count,
  output logic [7:0]    o_M_TX_Byte,
  output logic          o_M_TX_DV,
  input  logic          i_M_TX_Ready,
  input  logic          i_M_RX_DV,
  input  logic [7:0]    i_M_RX_Byte
);

  localparam int unsigned PW = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [PW-1:0] PerLast = PW'(PERIOD_CLKS - 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CLKS - 1);
  localparam logic [CW-1:0] IdxLast = CW'(NUM_BYTES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSend, StWaitRx, StDone} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] tx_word_q, tx_word_d;
  logic [WW-1:0] shadow_q, shadow_d;
  logic [WW-1:0] rx_word_q, rx_word_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] period_q, period_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          timeout_q, timeout_d;
  logic          overrun_q, overrun_d;

  logic          trigger;
  logic          tx_dv;
  logic [CW-1:0] pos;
  logic [7:0]    sel_byte;
  logic [WW-1:0] shadow_merged;

  // Period counter is parked at zero in manual mode so that entering periodic
  // mode always yields a full period before the first tick.
  always_comb begin
    period_d = '0;
    if (i_Mode) period_d = (period_q == PerLast) ? '0 : period_q + 1'b1;
  end

  assign trigger = i_Mode ? (period_q == PerLast) : i_Start;

  // Byte position within the word for the current index; the same position is
  // used for the outgoing byte and for the returning byte.
  assign pos = LSB_FIRST ? idx_q : IdxLast - idx_q;

  always_comb begin
    sel_byte      = '0;
    shadow_merged = shadow_q;
    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
      if (pos == CW'(b)) begin
        sel_byte                = tx_word_q[8*b +: 8];
        shadow_merged[8*b +: 8] = i_M_RX_Byte;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_word_d   = tx_word_q;
    shadow_d    = shadow_q;
    rx_word_d   = rx_word_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    frame_cnt_d = frame_cnt_q;
    byte_d      = byte_q;
    tx_dv       = 1'b0;
    // Clear first so that an error event in the same cycle wins.
    timeout_d   = i_Clear_Err ? 1'b0 : timeout_q;
    overrun_d   = i_Clear_Err ? 1'b0 : overrun_q;

    if (trigger && (state_q != StIdle)) overrun_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          tx_word_d = i_TX_Word;
          idx_d     = '0;
          tmo_d     = '0;
          state_d   = StLoad;
        end
      end
      StLoad: state_d = StSend;
      StSend: begin
        if (i_M_TX_Ready) begin
          tx_dv   = 1'b1;
          byte_d  = sel_byte;
          tmo_d   = '0;
          state_d = StWaitRx;
        end else if (tmo_q == TmoLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StWaitRx: begin
        if (i_M_RX_DV) begin
          shadow_d = shadow_merged;
          idx_d    = idx_q + 1'b1;
          tmo_d    = '0;
          if (idx_q == IdxLast) begin
            // Publish at the transition so results are visible alongside o_Done.
            rx_word_d   = shadow_merged;
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = StDone;
          end else begin
            state_d = StSend;
          end
        end else if (tmo_q == TmoLast) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= StIdle;
      tx_word_q   <= '0;
      shadow_q    <= '0;
      rx_word_q   <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      period_q    <= '0;
      frame_cnt_q <= '0;
      byte_q      <= '0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_word_q   <= tx_word_d;
      shadow_q    <= shadow_d;
      rx_word_q   <= rx_word_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      period_q    <= period_d;
      frame_cnt_q <= frame_cnt_d;
      byte_q      <= byte_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign o_Busy        = (state_q != StIdle);
  assign o_Done        = (state_q == StDone);
  assign o_RX_Word     = rx_word_q;
  assign o_Frame_Count = frame_cnt_q;
  assign o_Timeout     = timeout_q;
  assign o_Overrun     = overrun_q;
  assign o_M_TX_Count  = o_Busy ? CW'(NUM_BYTES) : '0;
  assign o_M_TX_DV     = tx_dv;
  // Byte is presented with DV and then held until the next DV.
  assign o_M_TX_Byte   = tx_dv ? sel_byte : byte_q;

endmodule

// File: tb/tb_spi_frame_sequencer.sv
module tb_spi_frame_sequencer;

  localparam int unsigned NB = 4;
  localparam int unsigned CW = $clog2(NB + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- DUT A: LSB first, echo slave ----------------
  logic          a_mode, a_start, a_clear;
  logic [31:0]   a_tx_word, a_rx_word;
  logic          a_busy, a_done, a_timeout, a_overrun;
  logic [15:0]   a_frame_count;
  logic [CW-1:0] a_m_tx_count;
  logic [7:0]    a_m_tx_byte, a_rx_byte, a_hold;
  logic          a_tx_dv, a_ready, a_rx_dv, a_withhold;
  int            a_lat;

  spi_frame_sequencer #(
    .NUM_BYTES(NB), .LSB_FIRST(1'b1), .PERIOD_CLKS(64), .TIMEOUT_CLKS(16)
  ) dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Mode(a_mode), .i_Start(a_start),
    .i_TX_Word(a_tx_word), .i_Clear_Err(a_clear), .o_Busy(a_busy), .o_Done(a_done),
    .o_RX_Word(a_rx_word), .o_Frame_Count(a_frame_count), .o_Timeout(a_timeout),
    .o_Overrun(a_overrun), .o_M_TX_Count(a_m_tx_count), .o_M_TX_Byte(a_m_tx_byte),
    .o_M_TX_DV(a_tx_dv), .i_M_TX_Ready(a_ready), .i_M_RX_DV(a_rx_dv),
    .i_M_RX_Byte(a_rx_byte)
  );

  // Slave/master stand-in: accepts a byte when ready, answers 3 cycles later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ready <= 1'b1; a_rx_dv <= 1'b0; a_rx_byte <= 8'h00; a_hold <= 8'h00; a_lat <= 0;
    end else begin
      a_rx_dv <= 1'b0;
      if (a_ready) begin
        if (a_tx_dv) begin a_ready <= 1'b0; a_hold <= a_m_tx_byte; a_lat <= 3; end
      end else if (a_lat == 1) begin
        a_ready <= 1'b1;
        if (!a_withhold) begin a_rx_dv <= 1'b1; a_rx_byte <= a_hold; end
      end else begin
        a_lat <= a_lat - 1;
      end
    end
  end

  logic [7:0] a_sent [256];
  int a_ns = 0, a_dones = 0;
  always @(posedge clk) begin
    if (a_tx_dv && a_ns < 256) begin a_sent[a_ns] <= a_m_tx_byte; a_ns <= a_ns + 1; end
    if (a_done) a_dones <= a_dones + 1;
  end

  // ---------------- DUT B: MSB first, table slave ----------------
  logic          b_start;
  logic [31:0]   b_tx_word, b_rx_word;
  logic          b_busy, b_done, b_timeout, b_overrun;
  logic [15:0]   b_frame_count;
  logic [CW-1:0] b_m_tx_count;
  logic [7:0]    b_m_tx_byte, b_rx_byte;
  logic          b_tx_dv, b_ready, b_rx_dv;
  int            b_lat, b_k;
  logic [7:0]    b_resp [4];

  spi_frame_sequencer #(
    .NUM_BYTES(NB), .LSB_FIRST(1'b0), .PERIOD_CLKS(64), .TIMEOUT_CLKS(16)
  ) dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Mode(1'b0), .i_Start(b_start),
    .i_TX_Word(b_tx_word), .i_Clear_Err(1'b0), .o_Busy(b_busy), .o_Done(b_done),
    .o_RX_Word(b_rx_word), .o_Frame_Count(b_frame_count), .o_Timeout(b_timeout),
    .o_Overrun(b_overrun), .o_M_TX_Count(b_m_tx_count), .o_M_TX_Byte(b_m_tx_byte),
    .o_M_TX_DV(b_tx_dv), .i_M_TX_Ready(b_ready), .i_M_RX_DV(b_rx_dv),
    .i_M_RX_Byte(b_rx_byte)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_ready <= 1'b1; b_rx_dv <= 1'b0; b_rx_byte <= 8'h00; b_lat <= 0; b_k <= 0;
    end else begin
      b_rx_dv <= 1'b0;
      if (b_ready) begin
        if (b_tx_dv) begin b_ready <= 1'b0; b_lat <= 3; end
      end else if (b_lat == 1) begin
        b_ready <= 1'b1; b_rx_dv <= 1'b1; b_rx_byte <= b_resp[b_k % 4]; b_k <= b_k + 1;
      end else begin
        b_lat <= b_lat - 1;
      end
    end
  end

  logic [7:0] b_sent [16];
  int b_ns = 0;
  always @(posedge clk) begin
    if (b_tx_dv && b_ns < 16) begin b_sent[b_ns] <= b_m_tx_byte; b_ns <= b_ns + 1; end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  int cnt_bad = 0;

  task automatic a_pulse_start(input logic [31:0] w);
    a_tx_word = w; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic a_wait_done(input string tag);
    int cyc = 0;
    while (!a_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (a_busy && a_m_tx_count != CW'(NB)) cnt_bad++;
    end
    check(tag, 64'(a_done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int s0, d0, cyc, ns, first, last, bad_gap;
  logic prev;
  logic [15:0] fc0;

  initial begin
    b_resp[0] = 8'hA1; b_resp[1] = 8'hB2; b_resp[2] = 8'hC3; b_resp[3] = 8'hD4;
    a_mode = 1'b0; a_start = 1'b0; a_clear = 1'b0; a_tx_word = '0; a_withhold = 1'b0;
    b_start = 1'b0; b_tx_word = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_flags", 64'({a_busy, a_done, a_timeout, a_overrun, a_tx_dv}), 64'd0);
    check("rst_master_if", 64'({a_m_tx_count, a_m_tx_byte}), 64'd0);
    check("rst_rx_word", 64'(a_rx_word), 64'd0);
    check("rst_frame_count", 64'(a_frame_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Manual frame, LSB first, echo
    s0 = a_ns; d0 = a_dones; cnt_bad = 0;
    a_pulse_start(32'h2C21160B);
    check("t1_busy_at_load", 64'({a_busy, a_tx_dv}), 64'd2);
    @(negedge clk);
    check("t1_first_dv", 64'({a_tx_dv, a_m_tx_byte}), 64'h10B);
    a_wait_done("t1_done_seen");
    check("t1_rx_word", 64'(a_rx_word), 64'h2C21160B);
    check("t1_frame_count", 64'(a_frame_count), 64'd1);
    check("t1_sent_order", 64'({a_sent[s0], a_sent[s0+1], a_sent[s0+2], a_sent[s0+3]}),
          64'h0B16212C);
    check("t1_tx_count_held", 64'(cnt_bad), 64'd0);
    @(negedge clk);
    check("t1_idle_after", 64'({a_busy, a_done}), 64'd0);
    check("t1_one_done", 64'(a_dones - d0), 64'd1);

    // MSB first with table slave
    b_tx_word = 32'h2C21160B; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 0;
    while (!b_done && cyc < 300) begin @(negedge clk); cyc++; end
    check("b_done_seen", 64'(b_done), 64'd1);
    check("b_sent_order", 64'({b_sent[0], b_sent[1], b_sent[2], b_sent[3]}), 64'h2C21160B);
    check("b_rx_word", 64'(b_rx_word), 64'hA1B2C3D4);
    check("b_frame_count", 64'(b_frame_count), 64'd1);
    @(negedge clk);

    // Overrun: trigger while busy
    d0 = a_dones;
    a_pulse_start(32'h55AA0FF0);
    repeat (3) @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("ovr_set", 64'(a_overrun), 64'd1);
    a_start = 1'b1; a_clear = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_clear = 1'b0;
    check("ovr_error_beats_clear", 64'(a_overrun), 64'd1);
    a_wait_done("ovr_done_seen");
    check("ovr_rx_word", 64'(a_rx_word), 64'h55AA0FF0);
    repeat (30) @(negedge clk);
    check("ovr_single_frame", 64'({a_busy, a_frame_count}), 64'd2);
    check("ovr_one_done", 64'(a_dones - d0), 64'd1);
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    check("ovr_cleared", 64'(a_overrun), 64'd0);

    // Timeout: master never returns a byte
    a_withhold = 1'b1; d0 = a_dones;
    a_pulse_start(32'hDEADBEEF);
    cyc = 1;
    while (!a_timeout && cyc < 60) begin @(negedge clk); cyc++; end
    check("to_latency", 64'(cyc), 64'd19);
    check("to_idle", 64'({a_busy, a_tx_dv, a_done}), 64'd0);
    check("to_rx_kept", 64'(a_rx_word), 64'h55AA0FF0);
    check("to_count_kept", 64'(a_frame_count), 64'd2);
    check("to_no_done", 64'(a_dones - d0), 64'd0);
    a_withhold = 1'b0;
    repeat (5) @(negedge clk);
    a_pulse_start(32'h11223344);
    a_wait_done("to_next_done");
    check("to_next_rx", 64'(a_rx_word), 64'h11223344);
    check("to_next_count", 64'(a_frame_count), 64'd3);
    check("to_sticky", 64'(a_timeout), 64'd1);
    @(negedge clk);
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    check("to_cleared", 64'(a_timeout), 64'd0);

    // Periodic mode, 64-clock period
    d0 = a_dones; fc0 = a_frame_count; a_mode = 1'b1;
    prev = 1'b0; ns = 0; first = 0; last = 0; bad_gap = 0;
    for (int c = 1; c <= 700 && ns < 10; c++) begin
      @(negedge clk);
      if (c == 12) check("per_start_ignored", 64'({a_busy, a_overrun}), 64'd0);
      if (a_busy && !prev) begin
        if (ns == 0) first = c;
        else if (c - last != 64) bad_gap++;
        last = c;
        ns++;
      end
      prev = a_busy;
      if (c == 10) a_start = 1'b1;
      if (c == 11) a_start = 1'b0;
    end
    // Mode change mid-frame must not abort the tenth frame.
    a_mode = 1'b0;
    check("per_starts", 64'(ns), 64'd10);
    check("per_first_start", 64'(first), 64'd64);
    check("per_gaps", 64'(bad_gap), 64'd0);
    a_wait_done("per_last_done");
    check("per_frame_count", 64'(a_frame_count - fc0), 64'd10);
    @(negedge clk);
    check("per_done_pulses", 64'(a_dones - d0), 64'd10);
    check("per_no_overrun", 64'(a_overrun), 64'd0);

    // Asynchronous reset during WAIT_RX of byte 2
    repeat (3) @(negedge clk);
    s0 = a_ns;
    a_pulse_start(32'hCAFEF00D);
    cyc = 0;
    while (a_ns < s0 + 3 && cyc < 100) begin @(negedge clk); cyc++; end
    check("rst_mid_reached", 64'(a_busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstm_flags", 64'({a_busy, a_done, a_timeout, a_overrun, a_tx_dv}), 64'd0);
    check("rstm_master_if", 64'({a_m_tx_count, a_m_tx_byte}), 64'd0);
    check("rstm_rx_word", 64'(a_rx_word), 64'd0);
    check("rstm_frame_count", 64'(a_frame_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a_pulse_start(32'h01020304);
    a_wait_done("rstm_next_done");
    check("rstm_next_count", 64'(a_frame_count), 64'd1);
    check("rstm_next_rx", 64'(a_rx_word), 64'h01020304);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_frame_sequencer.md
# spi_frame_sequencer

Parametrised frame sequencer that sits between control logic and one byte-level SPI master instance. It drives the master's byte handshake to shift out an N-byte frame from a parallel word, and reassembles the received bytes into a parallel word. Frames start on a manual strobe or from an internal periodic timer. Stalled handshakes are caught by a timeout, and triggers that arrive while busy are flagged as overruns.

## Interface
- NUM_BYTES, 4, bytes per frame (1..8); CW = $clog2(NUM_BYTES+1)
- LSB_FIRST, 1, 1: byte 0 = word[7:0] goes first; 0: word[8*NUM_BYTES-1 -: 8] goes first
- PERIOD_CLKS, 1048576, clocks between periodic triggers (≥ 2)
- TIMEOUT_CLKS, 4096, maximum clocks spent waiting on any single master handshake
- i_Clk  in  1  clock; every register is on the rising edge
- i_Rst_L  in  1  reset, asynchronous and active-low
- i_Mode  in  1  0 = manual (i_Start), 1 = periodic timer
- i_Start  in  1  single-cycle start strobe; honoured only when i_Mode = 0
- i_TX_Word  in  8*NUM_BYTES  frame payload, latched at frame start
- i_Clear_Err  in  1  clears o_Timeout and o_Overrun
- o_Busy  out  1  high whenever the state is not IDLE
- o_Done  out  1  one-cycle pulse when a frame completes
- o_RX_Word  out  8*NUM_BYTES  last completed received frame
- o_Frame_Count  out  16  count of completed frames, wraps
- o_Timeout  out  1  sticky error: a handshake timed out
- o_Overrun  out  1  sticky error: a trigger was dropped
- o_M_TX_Count  out  CW  connects to master i_TX_Count
- o_M_TX_Byte  out  8  connects to master i_TX_Byte
- o_M_TX_DV  out  1  connects to master i_TX_DV
- i_M_TX_Ready  in  1  connects to master o_TX_Ready
- i_M_RX_DV  in  1  connects to master o_RX_DV
- i_M_RX_Byte  in  8  connects to master o_RX_Byte

## Operation
- Reset values: every output is 0; internal state is IDLE, the period counter is 0, and the shadow RX register is 0.
- The master must be instantiated with MAX_BYTES_PER_CS ≥ NUM_BYTES so that CS stays asserted for the whole frame.
- Trigger = (i_Mode = 0 and i_Start) or (i_Mode = 1 and period tick).
- Period counter: runs only while i_Mode = 1 and is held at 0 while i_Mode = 0. It counts 0..PERIOD_CLKS-1 and wraps. A tick is asserted for one cycle at the count PERIOD_CLKS-1.
- State IDLE: on a trigger, latch i_TX_Word, clear the byte index and the timeout counter, then go to LOAD.
- State LOAD: drive o_M_TX_Count = NUM_BYTES (held until DONE), then go to SEND.
- State SEND: when i_M_TX_Ready = 1 and o_M_TX_DV = 0:
  - drive o_M_TX_Byte with the selected byte (index or NUM_BYTES-1-index, per LSB_FIRST);
  - pulse o_M_TX_DV for exactly 1 cycle;
  - clear the timeout counter and go to WAIT_RX.
- State WAIT_RX: on i_M_RX_DV, write i_M_RX_Byte into the shadow RX register at the same byte position as the byte that was sent, increment the index, and clear the timeout counter.
  - If index+1 = NUM_BYTES, go to DONE; otherwise go to SEND.
- State DONE: for 1 cycle, o_RX_Word ← shadow, o_Done = 1, o_Frame_Count += 1 (0xFFFF wraps to 0x0000). Then go to IDLE.
- Timeout: the counter increments every cycle in SEND and WAIT_RX. If it reaches TIMEOUT_CLKS-1 without progress:
  - set o_Timeout, drop o_M_TX_DV, go to IDLE;
  - o_RX_Word and o_Frame_Count are left unchanged and no o_Done pulse is issued.
- Overrun: a trigger seen in any state other than IDLE sets o_Overrun and is discarded; it is never queued.
- If i_Clear_Err arrives in the same cycle as a new error event, the error wins and the flag is set.
- A change of i_Mode mid-frame does not abort the frame; it only affects later triggers.
- Reset asserted mid-frame forces all outputs to reset values at once, including o_M_TX_DV = 0, and the partial frame is discarded.

## Timing
- Trigger at cycle T: o_Busy = 1 at T+1 (LOAD), the earliest o_M_TX_DV is at T+2.
- o_M_TX_Byte is valid in the same cycle as o_M_TX_DV and is held until the next DV.
- i_M_RX_DV for the last byte at cycle R: o_Done and the new o_RX_Word/o_Frame_Count are visible at R+1, and o_Busy = 0 at R+2.
- The earliest next trigger is accepted at R+2.
- Sequencer overhead per byte is 2 cycles beyond the master's own latency.

## Test plan
- Manual, NUM_BYTES=4, LSB_FIRST=1, i_TX_Word=0x2C21160B, slave echo model -> bytes sent in order 0B,16,21,2C; a single o_Done pulse; o_RX_Word=0x2C21160B; o_Frame_Count=1; o_M_TX_Count=4 throughout the frame.
- LSB_FIRST=0 with the same word and a slave returning A1,B2,C3,D4 -> bytes sent 2C,21,16,0B; o_RX_Word=0xA1B2C3D4.
- Periodic mode, PERIOD_CLKS=64 -> starts 64 clocks apart; after 10 periods o_Frame_Count=10. An i_Start pulse in this mode is ignored.
- Trigger while busy (i_Start at LOAD+3) -> o_Overrun=1, exactly one frame runs. i_Clear_Err then drops the flag to 0.
- i_M_RX_DV withheld, TIMEOUT_CLKS=16 -> o_Timeout=1 after 16 clocks; no o_Done; o_RX_Word and count unchanged; state back in IDLE, with a following frame completing normally.
- i_Rst_L low during WAIT_RX of byte 2 -> all outputs 0 asynchronously. After release, a manual frame completes with o_Frame_Count=1.
